// File: rtl/multi_config_counter_if.sv
// Request/response bundle for the multi-channel credit counter.
// The requester side drives the master modport; the counter sits on the slave modport.
interface multi_config_counter_if #(
    parameter int unsigned count_sz = 10,
    parameter int unsigned NUM_CHAN = 4,
    parameter int unsigned CHAN_W   = 2
);
    logic                increment_ena;
    logic [CHAN_W-1:0]   increment_chan;
    logic [count_sz-1:0] increment_v;
    logic                increment_rdy;

    logic                decrement_ena;
    logic [CHAN_W-1:0]   decrement_chan;
    logic [count_sz-1:0] decrement_v;
    logic                decrement_rdy;

    logic                maybe_decrement_ena;
    logic [CHAN_W-1:0]   maybe_decrement_chan;
    logic [count_sz-1:0] maybe_decrement_v;
    logic                maybe_decrement;
    logic                maybe_decrement_rdy;

    logic [CHAN_W-1:0]   read_chan;
    logic [count_sz-1:0] read;
    logic                read_rdy;

    logic [NUM_CHAN-1:0] positive;
    logic                positive_rdy;
    logic [NUM_CHAN-1:0] overflow;
    logic [NUM_CHAN-1:0] underflow;
    logic                err_clear_ena;

    modport master (
        output increment_ena, increment_chan, increment_v,
        output decrement_ena, decrement_chan, decrement_v,
        output maybe_decrement_ena, maybe_decrement_chan, maybe_decrement_v,
        output read_chan, err_clear_ena,
        input  increment_rdy, decrement_rdy, maybe_decrement, maybe_decrement_rdy,
        input  read, read_rdy, positive, positive_rdy, overflow, underflow
    );

    modport slave (
        input  increment_ena, increment_chan, increment_v,
        input  decrement_ena, decrement_chan, decrement_v,
        input  maybe_decrement_ena, maybe_decrement_chan, maybe_decrement_v,
        input  read_chan, err_clear_ena,
        output increment_rdy, decrement_rdy, maybe_decrement, maybe_decrement_rdy,
        output read, read_rdy, positive, positive_rdy, overflow, underflow
    );
endinterface

// File: rtl/multi_config_counter.sv
// NUM_CHAN independent saturating credit counters with a deferred increment path,
// same-cycle decrement, conditional try-decrement and sticky per-channel error flags.
module multi_config_counter #(
    parameter int unsigned count_sz   = 10,
    parameter int unsigned NUM_CHAN   = 4,
    parameter int unsigned CHAN_W     = 2,
    parameter int unsigned INIT_COUNT = 0
) (
    input logic                  CLK,
    input logic                  nRST,
    multi_config_counter_if.slave bus
);
    localparam int unsigned SumW = count_sz + 2;

    logic [count_sz-1:0] count_q [NUM_CHAN];
    logic [count_sz-1:0] count_d [NUM_CHAN];
    logic                pend_vld_q, pend_vld_d;
    logic [CHAN_W-1:0]   pend_chan_q, pend_chan_d;
    logic [count_sz-1:0] pend_v_q, pend_v_d;
    logic [NUM_CHAN-1:0] ovf_q, ovf_d;
    logic [NUM_CHAN-1:0] udf_q, udf_d;

    logic                mdec_ok;

    assign bus.increment_rdy       = 1'b1;
    assign bus.decrement_rdy       = 1'b1;
    assign bus.maybe_decrement_rdy = 1'b1;
    assign bus.read_rdy            = 1'b1;
    assign bus.positive_rdy        = 1'b1;
    assign bus.maybe_decrement     = mdec_ok;
    assign bus.overflow            = ovf_q;
    assign bus.underflow           = udf_q;

    // Channel lookups scan the array so an out-of-range select simply never hits.
    always_comb begin
        logic [count_sz-1:0] mdec_cur;
        logic [count_sz-1:0] avail;
        logic                mdec_hit;
        mdec_cur     = '0;
        mdec_hit     = 1'b0;
        bus.read     = '0;
        bus.positive = '0;
        for (int c = 0; c < NUM_CHAN; c++) begin
            if (bus.maybe_decrement_chan == CHAN_W'(c)) begin
                mdec_cur = count_q[c];
                mdec_hit = 1'b1;
            end
            if (bus.read_chan == CHAN_W'(c)) begin
                bus.read = count_q[c];
            end
            bus.positive[c] = |count_q[c];
        end
        // The pending increment deliberately does not contribute to avail.
        if (bus.decrement_ena && (bus.decrement_chan == bus.maybe_decrement_chan)) begin
            avail = (mdec_cur >= bus.decrement_v) ? mdec_cur - bus.decrement_v : '0;
        end else begin
            avail = mdec_cur;
        end
        mdec_ok = bus.maybe_decrement_ena && mdec_hit && (avail >= bus.maybe_decrement_v);
    end

    always_comb begin
        logic signed [SumW-1:0] sum;
        logic [count_sz-1:0]    pinc;
        logic [count_sz-1:0]    dec;
        logic [count_sz-1:0]    mdec;
        sum  = '0;
        pinc = '0;
        dec  = '0;
        mdec = '0;

        pend_vld_d  = bus.increment_ena;
        pend_chan_d = bus.increment_ena ? bus.increment_chan : pend_chan_q;
        pend_v_d    = bus.increment_ena ? bus.increment_v : pend_v_q;

        ovf_d = bus.err_clear_ena ? '0 : ovf_q;
        udf_d = bus.err_clear_ena ? '0 : udf_q;

        for (int c = 0; c < NUM_CHAN; c++) begin
            pinc = (pend_vld_q && (pend_chan_q == CHAN_W'(c))) ? pend_v_q : '0;
            dec  = (bus.decrement_ena && (bus.decrement_chan == CHAN_W'(c))) ?
                   bus.decrement_v : '0;
            mdec = (mdec_ok && (bus.maybe_decrement_chan == CHAN_W'(c))) ?
                   bus.maybe_decrement_v : '0;
            sum  = $signed({2'b00, count_q[c]}) + $signed({2'b00, pinc})
                 - $signed({2'b00, dec}) - $signed({2'b00, mdec});
            // sum spans [-2*max, 2*max], so bit count_sz flags overflow once non-negative.
            if (sum[SumW-1]) begin
                count_d[c] = '0;
                udf_d[c]   = 1'b1;
            end else if (sum[count_sz]) begin
                count_d[c] = '1;
                ovf_d[c]   = 1'b1;
            end else begin
                count_d[c] = sum[count_sz-1:0];
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int c = 0; c < NUM_CHAN; c++) begin
                count_q[c] <= count_sz'(INIT_COUNT);
            end
            pend_vld_q  <= 1'b0;
            pend_chan_q <= '0;
            pend_v_q    <= '0;
            ovf_q       <= '0;
            udf_q       <= '0;
        end else begin
            for (int c = 0; c < NUM_CHAN; c++) begin
                count_q[c] <= count_d[c];
            end
            pend_vld_q  <= pend_vld_d;
            pend_chan_q <= pend_chan_d;
            pend_v_q    <= pend_v_d;
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
        end
    end
endmodule

// File: tb/tb_multi_config_counter.sv
// Bench for multi_config_counter: a 10-bit/4-channel instance driven from a vector table
// with a scoreboard queue, and a 4-bit/5-channel instance for saturation and range corners.
module tb_multi_config_counter;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    multi_config_counter_if #(.count_sz(10), .NUM_CHAN(4), .CHAN_W(2)) bus_a ();
    multi_config_counter_if #(.count_sz(4), .NUM_CHAN(5), .CHAN_W(3)) bus_b ();

    multi_config_counter #(.count_sz(10), .NUM_CHAN(4), .CHAN_W(2), .INIT_COUNT(0)) dut_a (
        .CLK  (clk),
        .nRST (rst_n),
        .bus  (bus_a)
    );

    multi_config_counter #(.count_sz(4), .NUM_CHAN(5), .CHAN_W(3), .INIT_COUNT(0)) dut_b (
        .CLK  (clk),
        .nRST (rst_n),
        .bus  (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       inc_e;
        logic [1:0] inc_c;
        logic [9:0] inc_v;
        logic       dec_e;
        logic [1:0] dec_c;
        logic [9:0] dec_v;
        logic       md_e;
        logic [1:0] md_c;
        logic [9:0] md_v;
        logic       clr;
        logic [1:0] rc;
        logic [9:0] e_read;
        logic       e_md;
        logic [3:0] e_pos;
        logic [3:0] e_ovf;
        logic [3:0] e_udf;
    } vec_t;

    typedef struct {
        int         step;
        logic [9:0] read;
        logic       md;
        logic [3:0] pos;
        logic [3:0] ovf;
        logic [3:0] udf;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];

    function automatic void add(input logic ie, input int ic, input int iv,
                                input logic de, input int dc, input int dv,
                                input logic me, input int mc, input int mv,
                                input logic clr, input int rc, input int er,
                                input logic emd, input logic [3:0] ep,
                                input logic [3:0] eo, input logic [3:0] eu);
        vec_t v;
        v.inc_e = ie;  v.inc_c = 2'(ic);  v.inc_v = 10'(iv);
        v.dec_e = de;  v.dec_c = 2'(dc);  v.dec_v = 10'(dv);
        v.md_e  = me;  v.md_c  = 2'(mc);  v.md_v  = 10'(mv);
        v.clr   = clr; v.rc    = 2'(rc);  v.e_read = 10'(er);
        v.e_md  = emd; v.e_pos = ep;      v.e_ovf = eo; v.e_udf = eu;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        bus_a.increment_ena = 0; bus_a.increment_chan = 0; bus_a.increment_v = 0;
        bus_a.decrement_ena = 0; bus_a.decrement_chan = 0; bus_a.decrement_v = 0;
        bus_a.maybe_decrement_ena = 0; bus_a.maybe_decrement_chan = 0;
        bus_a.maybe_decrement_v = 0; bus_a.read_chan = 0; bus_a.err_clear_ena = 0;
        bus_b.increment_ena = 0; bus_b.increment_chan = 0; bus_b.increment_v = 0;
        bus_b.decrement_ena = 0; bus_b.decrement_chan = 0; bus_b.decrement_v = 0;
        bus_b.maybe_decrement_ena = 0; bus_b.maybe_decrement_chan = 0;
        bus_b.maybe_decrement_v = 0; bus_b.read_chan = 0; bus_b.err_clear_ena = 0;
    endtask

    initial begin
        exp_t e;
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        idle_all();

        //  inc         dec         mdec        clr rc read md pos      ovf      udf
        add(0, 0, 0,    0, 0, 0,    0, 0, 0,    0,  0, 0,    0, 4'b0000, 4'b0000, 4'b0000);
        add(1, 2, 5,    0, 0, 0,    0, 0, 0,    0,  2, 0,    0, 4'b0000, 4'b0000, 4'b0000);
        add(0, 0, 0,    0, 0, 0,    0, 0, 0,    0,  2, 0,    0, 4'b0000, 4'b0000, 4'b0000);
        add(1, 1, 3,    0, 0, 0,    0, 0, 0,    0,  2, 5,    0, 4'b0100, 4'b0000, 4'b0000);
        add(0, 0, 0,    0, 0, 0,    0, 0, 0,    0,  1, 0,    0, 4'b0100, 4'b0000, 4'b0000);
        add(0, 0, 0,    0, 0, 0,    1, 1, 4,    0,  1, 3,    0, 4'b0110, 4'b0000, 4'b0000);
        add(0, 0, 0,    0, 0, 0,    1, 1, 3,    0,  1, 3,    1, 4'b0110, 4'b0000, 4'b0000);
        add(1, 0, 10,   0, 0, 0,    0, 0, 0,    0,  1, 0,    0, 4'b0100, 4'b0000, 4'b0000);
        add(0, 0, 0,    0, 0, 0,    0, 0, 0,    0,  0, 0,    0, 4'b0100, 4'b0000, 4'b0000);
        add(0, 0, 0,    1, 0, 4,    1, 0, 7,    0,  0, 10,   0, 4'b0101, 4'b0000, 4'b0000);
        add(1, 0, 4,    0, 0, 0,    0, 0, 0,    0,  0, 6,    0, 4'b0101, 4'b0000, 4'b0000);
        add(0, 0, 0,    0, 0, 0,    0, 0, 0,    0,  0, 6,    0, 4'b0101, 4'b0000, 4'b0000);
        add(0, 0, 0,    1, 0, 4,    1, 0, 6,    0,  0, 10,   1, 4'b0101, 4'b0000, 4'b0000);
        add(1, 1, 1,    0, 0, 0,    0, 0, 0,    0,  0, 0,    0, 4'b0100, 4'b0000, 4'b0000);
        add(0, 0, 0,    0, 0, 0,    0, 0, 0,    0,  1, 0,    0, 4'b0100, 4'b0000, 4'b0000);
        add(1, 1, 2,    0, 0, 0,    0, 0, 0,    0,  1, 1,    0, 4'b0110, 4'b0000, 4'b0000);
        add(0, 0, 0,    1, 1, 1,    1, 1, 1,    0,  1, 1,    0, 4'b0110, 4'b0000, 4'b0000);
        add(1, 3, 1023, 0, 0, 0,    0, 0, 0,    0,  1, 2,    0, 4'b0110, 4'b0000, 4'b0000);
        add(0, 0, 0,    0, 0, 0,    0, 0, 0,    0,  3, 0,    0, 4'b0110, 4'b0000, 4'b0000);
        add(1, 3, 5,    0, 0, 0,    0, 0, 0,    0,  3, 1023, 0, 4'b1110, 4'b0000, 4'b0000);
        add(0, 0, 0,    0, 0, 0,    0, 0, 0,    0,  3, 1023, 0, 4'b1110, 4'b0000, 4'b0000);
        add(0, 0, 0,    0, 0, 0,    0, 0, 0,    1,  3, 1023, 0, 4'b1110, 4'b1000, 4'b0000);
        add(0, 0, 0,    1, 2, 6,    0, 0, 0,    0,  2, 5,    0, 4'b1110, 4'b0000, 4'b0000);
        add(0, 0, 0,    1, 2, 1,    0, 0, 0,    1,  2, 0,    0, 4'b1010, 4'b0000, 4'b0100);
        add(0, 0, 0,    0, 0, 0,    0, 0, 0,    1,  2, 0,    0, 4'b1010, 4'b0000, 4'b0100);
        add(0, 0, 0,    0, 0, 0,    1, 3, 1023, 0,  3, 1023, 1, 4'b1010, 4'b0000, 4'b0000);
        add(0, 0, 0,    0, 0, 0,    0, 0, 0,    0,  3, 0,    0, 4'b0010, 4'b0000, 4'b0000);

        #1;
        chk("rdy_in_reset_a", {bus_a.increment_rdy, bus_a.decrement_rdy,
            bus_a.maybe_decrement_rdy, bus_a.read_rdy, bus_a.positive_rdy}, 5'b11111);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            bus_a.increment_ena        = vecs[i].inc_e;
            bus_a.increment_chan       = vecs[i].inc_c;
            bus_a.increment_v          = vecs[i].inc_v;
            bus_a.decrement_ena        = vecs[i].dec_e;
            bus_a.decrement_chan       = vecs[i].dec_c;
            bus_a.decrement_v          = vecs[i].dec_v;
            bus_a.maybe_decrement_ena  = vecs[i].md_e;
            bus_a.maybe_decrement_chan = vecs[i].md_c;
            bus_a.maybe_decrement_v    = vecs[i].md_v;
            bus_a.err_clear_ena        = vecs[i].clr;
            bus_a.read_chan            = vecs[i].rc;
            e.step = i;
            e.read = vecs[i].e_read;
            e.md   = vecs[i].e_md;
            e.pos  = vecs[i].e_pos;
            e.ovf  = vecs[i].e_ovf;
            e.udf  = vecs[i].e_udf;
            exp_q.push_back(e);
            @(negedge clk);
            e = exp_q.pop_front();
            chk($sformatf("step%0d_read", e.step), 32'(bus_a.read), 32'(e.read));
            chk($sformatf("step%0d_mdec", e.step), 32'(bus_a.maybe_decrement), 32'(e.md));
            chk($sformatf("step%0d_positive", e.step), 32'(bus_a.positive), 32'(e.pos));
            chk($sformatf("step%0d_overflow", e.step), 32'(bus_a.overflow), 32'(e.ovf));
            chk($sformatf("step%0d_underflow", e.step), 32'(bus_a.underflow), 32'(e.udf));
            tick();
        end
        idle_all();

        // Small instance: saturation, truncated amounts, clear, out-of-range channels.
        bus_b.increment_ena = 1; bus_b.increment_chan = 3; bus_b.increment_v = 4'd14;
        tick();
        bus_b.increment_ena = 0;
        tick();
        bus_b.read_chan = 3;
        #1 chk("b_ch3_14", 32'(bus_b.read), 14);
        bus_b.increment_ena = 1; bus_b.increment_v = 4'd5;
        tick();
        bus_b.increment_ena = 0;
        tick();
        chk("b_ch3_sat", 32'(bus_b.read), 15);
        chk("b_ovf_set", 32'(bus_b.overflow), 32'h08);
        bus_b.err_clear_ena = 1;
        tick();
        bus_b.err_clear_ena = 0;
        chk("b_ovf_clr", 32'(bus_b.overflow), 0);
        bus_b.decrement_ena = 1; bus_b.decrement_chan = 3; bus_b.decrement_v = 4'(20);
        tick();
        bus_b.decrement_ena = 0;
        chk("b_dec_trunc", 32'(bus_b.read), 11);
        chk("b_no_udf", 32'(bus_b.underflow), 0);
        bus_b.decrement_ena = 1; bus_b.decrement_v = 4'd12;
        tick();
        bus_b.decrement_ena = 0;
        chk("b_dec_clamp", 32'(bus_b.read), 0);
        chk("b_udf_set", 32'(bus_b.underflow), 32'h08);
        bus_b.read_chan = 6;
        bus_b.maybe_decrement_ena = 1; bus_b.maybe_decrement_chan = 6;
        bus_b.maybe_decrement_v = 0;
        #1 chk("b_oor_mdec", 32'(bus_b.maybe_decrement), 0);
        bus_b.maybe_decrement_chan = 0;
        #1 chk("b_mdec_zero_ok", 32'(bus_b.maybe_decrement), 1);
        bus_b.maybe_decrement_ena = 0;
        bus_b.increment_ena = 1; bus_b.increment_chan = 6; bus_b.increment_v = 4'd3;
        tick();
        bus_b.increment_ena = 0;
        tick();
        chk("b_oor_read", 32'(bus_b.read), 0);
        chk("b_oor_positive", 32'(bus_b.positive), 0);

        // Reset lands while an increment is pending; it must not be replayed.
        bus_a.read_chan = 0;
        bus_a.increment_ena = 1; bus_a.increment_chan = 0; bus_a.increment_v = 10'd7;
        tick();
        bus_a.increment_ena = 0;
        rst_n = 1'b0;
        #1;
        chk("rst_rdy_a", {bus_a.increment_rdy, bus_a.decrement_rdy,
            bus_a.maybe_decrement_rdy, bus_a.read_rdy, bus_a.positive_rdy}, 5'b11111);
        chk("rst_udf_b", 32'(bus_b.underflow), 0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("rst_pend_lost", 32'(bus_a.read), 0);
        chk("rst_positive", 32'(bus_a.positive), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
